// File: rtl/mem_interface_pkg.sv
// Shared encodings for the RV64 dataflow memory bridge: access sizes, error codes, FSM states.
package mem_if_pkg;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_t;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_MISALIGN = 2'b01, ERR_TIMEOUT = 2'b10} err_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  function automatic logic [7:0] byte_mask(size_t s);
    case (s)
      SZ_B:    byte_mask = 8'h01;
      SZ_H:    byte_mask = 8'h03;
      SZ_W:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_interface_if.sv
// 64-bit variable-latency memory port; master drives the request, slave answers with ready/rdata.
interface mem_interface_if #(parameter int AW = 64);
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_wstrb;
  logic          mem_ready;
  logic [63:0]   mem_rdata;

  modport master (output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_interface_lane_align.sv
// Byte-lane steering: strobes, store-data shift, right-aligned zero-filled load data, misalign check.
module lane_align
  import mem_if_pkg::*;
(
  input  size_t       size,
  input  logic [2:0]  addr,
  input  logic [63:0] wdata,
  input  logic [63:0] mem_rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_al,
  output logic        misaligned
);
  logic [7:0]  size_mask;
  logic [63:0] rdata_sh;

  assign size_mask = byte_mask(size);
  assign wstrb     = size_mask << addr;
  assign wdata_sh  = wdata << {addr, 3'b000};
  assign rdata_sh  = mem_rdata >> {addr, 3'b000};

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign rdata_al[8*i +: 8] = size_mask[i] ? rdata_sh[8*i +: 8] : 8'h00;
  end

  always_comb begin
    case (size)
      SZ_H:    misaligned = addr[0];
      SZ_W:    misaligned = |addr[1:0];
      SZ_D:    misaligned = |addr;
      default: misaligned = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_interface.sv
// Single-request load/store bridge from the multicycle dataflow to a variable-latency memory port.
module mem_interface
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          write,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [63:0]   rdata_o,
  mem_interface_if.master mem
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic          we_q;
  size_t         size_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic [7:0]    to_cnt;

  logic          idle, in_busy;
  size_t         la_size;
  logic [2:0]    la_addr;
  logic [63:0]   la_wdata;
  logic [7:0]    strb;
  logic [63:0]   wdata_sh, rdata_al;
  logic          misal;

  assign idle    = (state == IDLE);
  assign in_busy = (state == BUSY);

  // In IDLE the aligner checks the incoming request; afterwards it serves the captured one.
  assign la_size  = idle ? size_t'(size) : size_q;
  assign la_addr  = idle ? addr[2:0]     : addr_q[2:0];
  assign la_wdata = idle ? wdata         : wdata_q;

  lane_align u_align (
    .size      (la_size),
    .addr      (la_addr),
    .wdata     (la_wdata),
    .mem_rdata (mem.mem_rdata),
    .wstrb     (strb),
    .wdata_sh  (wdata_sh),
    .rdata_al  (rdata_al),
    .misaligned(misal)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = misal ? ERR : BUSY;
      BUSY:    if (mem.mem_ready)          state_nx = DONE;
               else if (to_cnt == TO_LAST) state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_code <= ERR_NONE;
      rdata_o  <= '0;
      to_cnt   <= '0;
    end else begin
      if (idle && start) begin
        we_q     <= write;
        size_q   <= size_t'(size);
        addr_q   <= addr;
        wdata_q  <= wdata;
        err_code <= misal ? ERR_MISALIGN : ERR_NONE;
      end
      if (in_busy && !mem.mem_ready && to_cnt == TO_LAST) err_code <= ERR_TIMEOUT;
      if (in_busy && mem.mem_ready && !we_q)              rdata_o  <= rdata_al;
      if (!in_busy)            to_cnt <= '0;
      else if (!mem.mem_ready) to_cnt <= to_cnt + 8'd1;
    end
  end

  assign busy  = !idle;
  assign done  = (state == DONE) || (state == ERR);
  assign error = (state == ERR);

  assign mem.mem_valid = in_busy;
  assign mem.mem_we    = in_busy && we_q;
  assign mem.mem_addr  = in_busy ? {addr_q[AW-1:3], 3'b000} : '0;
  assign mem.mem_wdata = in_busy ? wdata_sh : '0;
  assign mem.mem_wstrb = (in_busy && we_q) ? strb : 8'h00;
endmodule

// File: tb/tb_mem_interface.sv
// Directed + randomized checks of mem_interface against a byte-level reference model.
module tb_mem_interface;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, start, write;
  logic [1:0]  size;
  logic [63:0] addr, wdata;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [63:0] rdata_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_rdata = '0;

  mem_interface_if #(.AW(64)) mif ();

  mem_interface #(.TIMEOUT(TO), .AW(64)) dut (
    .clk(clk), .reset(reset), .start(start), .write(write), .size(size),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .rdata_o(rdata_o), .mem(mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // dly = index of the valid cycle in which memory answers; >= TO means never.
  task automatic txn(input logic w, input logic [1:0] sz, input logic [63:0] a,
                     input logic [63:0] wd, input int dly, input logic [63:0] rd,
                     input bit stray);
    int nb, off;
    bit mis, fin;
    logic [7:0]  es;
    logic [63:0] ewd, erd;
    nb  = 1 << sz;
    off = int'(a[2:0]);
    mis = (off % nb) != 0;
    es = '0; ewd = '0; erd = '0;
    if (!mis) begin
      for (int i = 0; i < nb; i++) begin
        es[off+i] = 1'b1;
        erd[8*i +: 8] = rd[8*(off+i) +: 8];
      end
      for (int i = 0; i + off < 8; i++) ewd[8*(off+i) +: 8] = wd[8*i +: 8];
    end
    start = 1'b1; write = w; size = sz; addr = a; wdata = wd;
    step();
    start = 1'b0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    if (mis) begin
      chk("mis_valid", 64'(mif.mem_valid), 64'd0);
      chk("mis_done",  64'(done),  64'd1);
      chk("mis_error", 64'(error), 64'd1);
      chk("mis_code",  64'(err_code), 64'd1);
      chk("mis_rdata", rdata_o, exp_rdata);
      start = stray;
    end else begin
      fin = 1'b0;
      for (int k = 0; k < TO && !fin; k++) begin
        chk("valid", 64'(mif.mem_valid), 64'd1);
        chk("we",    64'(mif.mem_we), 64'(w));
        chk("maddr", mif.mem_addr, {a[63:3], 3'b000});
        chk("wstrb", 64'(mif.mem_wstrb), w ? 64'(es) : 64'd0);
        if (w) chk("mwdata", mif.mem_wdata, ewd);
        chk("busy_done", {62'd0, busy, done}, 64'd2);
        mif.mem_ready = (k == dly);
        mif.mem_rdata = (k == dly) ? rd : {$urandom, $urandom};
        start = stray && ($urandom_range(0, 1) == 1);
        step();
        mif.mem_ready = 1'b0;
        if (k == dly) begin
          if (!w) exp_rdata = erd;
          chk("ok_done",  64'(done),  64'd1);
          chk("ok_error", 64'(error), 64'd0);
          chk("ok_code",  64'(err_code), 64'd0);
          fin = 1'b1;
        end else if (k == TO - 1) begin
          chk("to_done",  64'(done),  64'd1);
          chk("to_error", 64'(error), 64'd1);
          chk("to_code",  64'(err_code), 64'd2);
          fin = 1'b1;
        end
      end
      chk("end_valid", 64'(mif.mem_valid), 64'd0);
      chk("rdata", rdata_o, exp_rdata);
      start = stray;
    end
    step();
    start = 1'b0;
    // a start coinciding with done must have been dropped
    chk("idle_busy",  64'(busy), 64'd0);
    chk("idle_valid", 64'(mif.mem_valid), 64'd0);
    chk("idle_done",  64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; write = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    step(); step();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_code",  64'(err_code), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_valid", 64'(mif.mem_valid), 64'd0);
    chk("rst_we",    64'(mif.mem_we), 64'd0);
    chk("rst_addr",  mif.mem_addr, 64'd0);
    chk("rst_wdata", mif.mem_wdata, 64'd0);
    chk("rst_wstrb", 64'(mif.mem_wstrb), 64'd0);
    reset = 1'b1;
    step();

    txn(1'b1, 2'b11, 64'h1000, 64'h0123456789ABCDEF, 0, 64'h0, 1'b0);
    txn(1'b1, 2'b00, 64'h1003, 64'h00000000000000AB, 2, 64'h0, 1'b1);
    txn(1'b0, 2'b10, 64'h1004, 64'h0, 1, 64'hDEADBEEF12345678, 1'b0);
    chk("lw_value", rdata_o, 64'h00000000DEADBEEF);
    txn(1'b0, 2'b00, 64'h1001, 64'h0, 0, 64'hDEADBEEF12345678, 1'b0);
    chk("lb_value", rdata_o, 64'h0000000000000056);
    txn(1'b0, 2'b01, 64'h1001, 64'h0, 0, 64'h0, 1'b1);
    txn(1'b0, 2'b11, 64'h2000, 64'h0, TO + 5, 64'h1111, 1'b1);
    txn(1'b0, 2'b11, 64'h2008, 64'h0, TO - 1, 64'hCAFEF00D55AA33CC, 1'b0);
    chk("ld_last_ok", rdata_o, 64'hCAFEF00D55AA33CC);

    for (int r = 0; r < 60; r++) begin
      logic [63:0] ra, rw, rr;
      logic [1:0]  rs;
      int          rd_dly;
      rs = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) ra[2:0] = ra[2:0] & ~3'((1 << rs) - 1);
      rw = {$urandom, $urandom};
      rr = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rd_dly = TO + 2;
        1:       rd_dly = TO - 1;
        default: rd_dly = $urandom_range(0, 5);
      endcase
      txn(1'($urandom_range(0, 1)), rs, ra, rw, rd_dly, rr, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a transfer, with stray starts while busy
    start = 1'b1; write = 1'b0; size = 2'b11; addr = 64'h3000;
    step();
    for (int k = 0; k < 3; k++) begin
      start = 1'($urandom_range(0, 1));
      addr = 64'h4000;
      chk("pre_rst_valid", 64'(mif.mem_valid), 64'd1);
      step();
    end
    start = 1'b0; reset = 1'b0;
    step();
    exp_rdata = '0;
    chk("mid_rst_valid", 64'(mif.mem_valid), 64'd0);
    chk("mid_rst_done",  64'(done), 64'd0);
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_rdata", rdata_o, exp_rdata);
    chk("mid_rst_addr",  mif.mem_addr, 64'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_valid", 64'(mif.mem_valid), 64'd0);
      chk("post_rst_done",  64'(done), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
